// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mult_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/adder_32b.sv
// 32-bit ripple adder with carry-out and signed-overflow flag.
module adder_32b (
    input  logic [31:0] i0,
    input  logic [31:0] i1,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovflw
);

    always_comb begin
        {cout, sum} = {1'b0, i0} + {1'b0, i1} + {32'd0, cin};
        // Two's-complement overflow: same-sign operands, result sign differs
        ovflw = (i0[31] == i1[31]) && (sum[31] != i0[31]);
    end

endmodule

// File: rtl/mult_32b_seq.sv
// Unsigned 32x32 shift-add multiplier; one partial-product step per clock,
// 64-bit registered product with a one-cycle done pulse.
module mult_32b_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [2*WIDTH-1:0] product
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, acc_hi, acc_lo;
    logic [CNT_W-1:0]   count;

    logic [WIDTH-1:0]   add_i1, add_sum;
    logic               add_cout;
    logic               adder_ovflw_unused;
    logic [WIDTH-1:0]   acc_hi_nxt, acc_lo_nxt;
    logic               last_iter;

    assign add_i1 = acc_lo[0] ? mcand : '0;

    adder_32b u_adder (
        .i0    (acc_hi),
        .i1    (add_i1),
        .cin   (1'b0),
        .sum   (add_sum),
        .cout  (add_cout),
        .ovflw (adder_ovflw_unused)
    );

    // 65-bit {cout, sum, acc_lo} >> 1: carry lands in the product MSB
    assign acc_hi_nxt = {add_cout, add_sum[WIDTH-1:1]};
    assign acc_lo_nxt = {add_sum[0], acc_lo[WIDTH-1:1]};
    assign last_iter  = (count == CNT_W'(ITER - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (last_iter) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        acc_hi <= '0;
                        acc_lo <= b;
                        count  <= '0;
                    end
                end
                S_CALC: begin
                    acc_hi <= acc_hi_nxt;
                    acc_lo <= acc_lo_nxt;
                    count  <= count + 1'b1;
                    if (last_iter) product <= {acc_hi_nxt, acc_lo_nxt};
                end
                default: ;
            endcase
        end
    end

endmodule
